oled_rx: RTL and testbench

Responder end of the OLED parallel command/data bus. It samples the strobes `oled_cs`, `oled_e` and `oled_dc` and the 8-bit `oled_din`. It groups bytes into commands with their arguments and turns RAM-write data into addressed RGB565 pixel writes. It is used as the display-side model in simulation, and as the decoder in front of a framebuffer capture block.

---
 rtl/oled_pkg.sv | 26 ++
 rtl/oled_rx_if.sv | 11 +
 rtl/oled_rx_addr_gen.sv | 76 +++++++
 rtl/oled_rx.sv | 205 ++++++++++++++++++++
 tb/tb_oled_rx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared opcodes, arity lookup and receiver state encoding for the
// OLED parallel command/data bus.
package oled_pkg;

    localparam logic [7:0] CMD_SET_COL   = 8'h15;
    localparam logic [7:0] CMD_SET_ROW   = 8'h75;
    localparam logic [7:0] CMD_WRITE_RAM = 8'h5C;
    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_ARG,
        ST_RAM
    } state_t;

    function automatic logic [1:0] arity(input logic [7:0] op);
        case (op)
            8'h15, 8'h75, 8'hA0, 8'hB4, 8'hD1: arity = 2'd2;
            8'hAE, 8'hAF, 8'h5C:               arity = 2'd0;
            default:                           arity = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/oled_rx_if.sv
// OLED parallel bus: chip select, write strobe, data/command flag, byte.
// The host side drives it (master), the receiver samples it (slave).
interface oled_rx_if;
    logic       oled_cs;
    logic       oled_e;
    logic       oled_dc;
    logic [7:0] oled_din;

    modport master (output oled_cs, oled_e, oled_dc, oled_din);
    modport slave  (input  oled_cs, oled_e, oled_dc, oled_din);
endinterface

// File: rtl/oled_rx_addr_gen.sv
// Drawing window registers with clamping, plus the x/y write pointer
// that walks the window row by row and wraps to its top-left corner.
module oled_rx_addr_gen #(
    parameter int COLS = 96,
    parameter int ROWS = 64,
    parameter int X_W  = $clog2(COLS),
    parameter int Y_W  = $clog2(ROWS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_col,
    input  logic           load_row,
    input  logic           ptr_rst,
    input  logic           advance,
    input  logic [7:0]     a0,
    input  logic [7:0]     a1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y
);

    localparam logic [X_W-1:0] X_MAX = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(ROWS - 1);

    logic [X_W-1:0] col_start, col_end, cs_c, ce_c;
    logic [Y_W-1:0] row_start, row_end, rs_c, re_c;

    function automatic logic [X_W-1:0] clamp_x(input logic [7:0] v);
        clamp_x = (int'(v) > COLS - 1) ? X_MAX : X_W'(v);
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [7:0] v);
        clamp_y = (int'(v) > ROWS - 1) ? Y_MAX : Y_W'(v);
    endfunction

    // An inverted window collapses to a single line at its start.
    always_comb begin
        cs_c = clamp_x(a0);
        ce_c = clamp_x(a1);
        if (ce_c < cs_c) ce_c = cs_c;
        rs_c = clamp_y(a0);
        re_c = clamp_y(a1);
        if (re_c < rs_c) re_c = rs_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_start <= '0;
            col_end   <= X_MAX;
            row_start <= '0;
            row_end   <= Y_MAX;
            x         <= '0;
            y         <= '0;
        end else if (load_col) begin
            col_start <= cs_c;
            col_end   <= ce_c;
            x         <= cs_c;
            y         <= row_start;
        end else if (load_row) begin
            row_start <= rs_c;
            row_end   <= re_c;
            x         <= col_start;
            y         <= rs_c;
        end else if (ptr_rst) begin
            x <= col_start;
            y <= row_start;
        end else if (advance) begin
            if (x == col_end) begin
                x <= col_start;
                y <= (y == row_end) ? row_start : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oled_rx.sv
// OLED bus responder: groups bytes into commands and RGB565 pixel writes.
// Define OLED_RX_SYNC_EN to put 2-flop synchronizers on the bus inputs.
module oled_rx
    import oled_pkg::*;
#(
    parameter int COLS = 96,
    parameter int ROWS = 64,
    parameter int X_W  = $clog2(COLS),
    parameter int Y_W  = $clog2(ROWS)
) (
    input  logic           clk,
    input  logic           rst,
    oled_rx_if.slave       bus,
    output logic           cmd_valid,
    output logic [7:0]     cmd_code,
    output logic [15:0]    cmd_args,
    output logic           pix_valid,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic [15:0]    pix_data,
    output logic           disp_on,
    output logic           err
);

    logic       cs_s, e_s, dc_s;
    logic [7:0] din_s;

`ifdef OLED_RX_SYNC_EN
    logic [1:0] cs_sy, e_sy, dc_sy;
    logic [7:0] din_s1, din_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sy  <= 2'b11;
            e_sy   <= 2'b00;
            dc_sy  <= 2'b00;
            din_s1 <= '0;
            din_s2 <= '0;
        end else begin
            cs_sy  <= {cs_sy[0], bus.oled_cs};
            e_sy   <= {e_sy[0], bus.oled_e};
            dc_sy  <= {dc_sy[0], bus.oled_dc};
            din_s1 <= bus.oled_din;
            din_s2 <= din_s1;
        end
    end

    assign cs_s  = cs_sy[1];
    assign e_s   = e_sy[1];
    assign dc_s  = dc_sy[1];
    assign din_s = din_s2;
`else
    assign cs_s  = bus.oled_cs;
    assign e_s   = bus.oled_e;
    assign dc_s  = bus.oled_dc;
    assign din_s = bus.oled_din;
`endif

    state_t     state, state_d;
    logic       e_q, stb;
    logic [7:0] opcode, arg0, hi;
    logic [1:0] arg_cnt;
    logic       arg_idx, phase;

    logic        op_take, arg_take, pix_take, err_set;
    logic        cmd_fire, pix_fire;
    logic [7:0]  fire_code;
    logic [15:0] fire_args;
    logic [X_W-1:0] ptr_x;
    logic [Y_W-1:0] ptr_y;

    assign stb = !cs_s && e_q && !e_s;

    function automatic state_t after_op(input logic [7:0] op);
        if (arity(op) != 2'd0)      after_op = ST_ARG;
        else if (op == CMD_WRITE_RAM) after_op = ST_RAM;
        else                          after_op = ST_CMD;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (!cs_s) state_d = ST_CMD;
            ST_CMD: if (stb && !dc_s) state_d = after_op(din_s);
            ST_ARG: begin
                if (stb && !dc_s)
                    state_d = after_op(din_s);
                else if (stb && arg_cnt == 2'd1)
                    state_d = ST_CMD;
            end
            ST_RAM: if (stb && !dc_s) state_d = after_op(din_s);
            default: state_d = ST_IDLE;
        endcase
        // Deselect wins after any byte taken in this same cycle.
        if (cs_s) state_d = ST_IDLE;
    end

    always_comb begin
        op_take   = 1'b0;
        arg_take  = 1'b0;
        pix_take  = 1'b0;
        err_set   = 1'b0;
        cmd_fire  = 1'b0;
        fire_code = opcode;
        fire_args = '0;
        unique case (state)
            ST_CMD: begin
                op_take = stb && !dc_s;
                err_set = stb && dc_s;
            end
            ST_ARG: begin
                op_take  = stb && !dc_s;
                err_set  = stb && !dc_s;
                arg_take = stb && dc_s;
            end
            ST_RAM: begin
                op_take  = stb && !dc_s;
                pix_take = stb && dc_s;
            end
            default: ;
        endcase
        if (op_take && arity(din_s) == 2'd0) begin
            cmd_fire  = 1'b1;
            fire_code = din_s;
        end else if (arg_take && arg_cnt == 2'd1) begin
            cmd_fire  = 1'b1;
            fire_args = arg_idx ? {arg0, din_s} : {din_s, 8'h00};
        end
        pix_fire = pix_take && phase;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q       <= 1'b0;
            opcode    <= '0;
            arg0      <= '0;
            arg_cnt   <= '0;
            arg_idx   <= 1'b0;
            phase     <= 1'b0;
            hi        <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_args  <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= '0;
            disp_on   <= 1'b0;
            err       <= 1'b0;
        end else begin
            e_q <= e_s;
            if (op_take) begin
                opcode  <= din_s;
                arg_cnt <= arity(din_s);
                arg_idx <= 1'b0;
                arg0    <= '0;
            end else if (arg_take) begin
                arg_cnt <= arg_cnt - 2'd1;
                arg_idx <= 1'b1;
                if (!arg_idx) arg0 <= din_s;
            end
            if (cs_s || op_take) phase <= 1'b0;
            else if (pix_take)   phase <= ~phase;
            if (pix_take && !phase) hi <= din_s;
            cmd_valid <= cmd_fire;
            if (cmd_fire) begin
                cmd_code <= fire_code;
                cmd_args <= fire_args;
            end
            pix_valid <= pix_fire;
            if (pix_fire) begin
                pix_data <= {hi, din_s};
                pix_x    <= ptr_x;
                pix_y    <= ptr_y;
            end
            if (err_set) err <= 1'b1;
            if (cmd_fire && fire_code == CMD_DISP_ON)       disp_on <= 1'b1;
            else if (cmd_fire && fire_code == CMD_DISP_OFF) disp_on <= 1'b0;
        end
    end

    oled_rx_addr_gen #(
        .COLS (COLS),
        .ROWS (ROWS),
        .X_W  (X_W),
        .Y_W  (Y_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_col (cmd_fire && fire_code == CMD_SET_COL),
        .load_row (cmd_fire && fire_code == CMD_SET_ROW),
        .ptr_rst  (cmd_fire && fire_code == CMD_WRITE_RAM),
        .advance  (pix_fire),
        .a0       (fire_args[15:8]),
        .a1       (fire_args[7:0]),
        .x        (ptr_x),
        .y        (ptr_y)
    );

endmodule

// File: tb/tb_oled_rx.sv
// Directed bench for oled_rx: expected commands and pixels are queued
// when bytes are sent and compared as the receiver pulses them out.
module tb_oled_rx;
    import oled_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, pix_valid, disp_on, err;
    logic [7:0] cmd_code;
    logic [15:0] cmd_args, pix_data;
    logic [6:0] pix_x;
    logic [5:0] pix_y;

    int checks   = 0;
    int failures = 0;

    logic [23:0] cmd_q[$];
    logic [31:0] pix_q[$];

    oled_rx_if bus();

    oled_rx dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_args  (cmd_args),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_data  (pix_data),
        .disp_on   (disp_on),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] ce;
        logic [31:0] pe;
        if (rst === 1'b1 && cmd_valid === 1'b1) begin
            checks++;
            ce = (cmd_q.size() != 0) ? cmd_q.pop_front() : 24'hxxxxxx;
            assert ({cmd_code, cmd_args} === ce) else begin
                failures++;
                $error("FAIL cmd obs=%0h exp=%0h", {cmd_code, cmd_args}, ce);
            end
        end
        if (rst === 1'b1 && pix_valid === 1'b1) begin
            checks++;
            pe = (pix_q.size() != 0) ? pix_q.pop_front() : 32'hxxxxxxxx;
            assert ({8'(pix_x), 8'(pix_y), pix_data} === pe) else begin
                failures++;
                $error("FAIL pix obs=%0h exp=%0h",
                       {8'(pix_x), 8'(pix_y), pix_data}, pe);
            end
        end
    end

    task automatic send(input logic dc, input logic [7:0] d);
        @(posedge clk); #1;
        bus.oled_dc  = dc;
        bus.oled_din = d;
        bus.oled_e   = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.oled_e = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic cmd(input logic [7:0] op);
        send(1'b0, op);
    endtask

    task automatic dat(input logic [7:0] d);
        send(1'b1, d);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (cmd_q.size() + pix_q.size()) != 0; i++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        #1 chk(tag, 32'(cmd_q.size() + pix_q.size()), 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        bus.oled_cs  = 1'b1;
        bus.oled_e   = 1'b0;
        bus.oled_dc  = 1'b0;
        bus.oled_din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_disp_on", 32'(disp_on), 32'd0);
        chk("rst_cmd", 32'({cmd_code, cmd_args}), 32'd0);
        chk("rst_pix", 32'({pix_x, pix_y, pix_data}), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1 bus.oled_cs = 1'b0;
        repeat (4) @(posedge clk);

        cmd_q.push_back({CMD_DISP_ON, 16'h0000});
        cmd(CMD_DISP_ON);
        drain("drain_disp_on");
        chk("disp_on_set", 32'(disp_on), 32'd1);

        cmd_q.push_back({CMD_SET_COL, 16'h0203});
        cmd(CMD_SET_COL); dat(8'h02); dat(8'h03);
        cmd_q.push_back({CMD_SET_ROW, 16'h0102});
        cmd(CMD_SET_ROW); dat(8'h01); dat(8'h02);
        cmd_q.push_back({CMD_WRITE_RAM, 16'h0000});
        cmd(CMD_WRITE_RAM);
        pix_q.push_back({8'd2, 8'd1, 16'h1234});
        pix_q.push_back({8'd3, 8'd1, 16'h5678});
        pix_q.push_back({8'd2, 8'd2, 16'h9ABC});
        pix_q.push_back({8'd3, 8'd2, 16'hDEF0});
        pix_q.push_back({8'd2, 8'd1, 16'h1122});
        dat(8'h12); dat(8'h34); dat(8'h56); dat(8'h78);
        dat(8'h9A); dat(8'hBC); dat(8'hDE); dat(8'hF0);
        dat(8'h11); dat(8'h22);
        drain("drain_window");
        chk("err_clean", 32'(err), 32'd0);

        cmd_q.push_back({CMD_SET_COL, 16'hFF10});
        cmd(CMD_SET_COL); dat(8'hFF); dat(8'h10);
        cmd_q.push_back({CMD_SET_ROW, 16'h003F});
        cmd(CMD_SET_ROW); dat(8'h00); dat(8'h3F);
        cmd_q.push_back({CMD_WRITE_RAM, 16'h0000});
        cmd(CMD_WRITE_RAM);
        pix_q.push_back({8'd95, 8'd0, 16'hAAAA});
        pix_q.push_back({8'd95, 8'd1, 16'hBBBB});
        dat(8'hAA); dat(8'hAA); dat(8'hBB); dat(8'hBB);
        drain("drain_clamp");

        cmd(8'hA0);
        cmd_q.push_back({CMD_SET_ROW, 16'h0506});
        cmd(CMD_SET_ROW); dat(8'h05); dat(8'h06);
        drain("drain_abort");
        chk("err_abort", 32'(err), 32'd1);
        chk("code_after_abort", 32'(cmd_code), 32'(CMD_SET_ROW));

        cmd_q.push_back({CMD_SET_COL, 16'h1011});
        cmd(CMD_SET_COL); dat(8'h10); dat(8'h11);
        cmd_q.push_back({CMD_WRITE_RAM, 16'h0000});
        cmd(CMD_WRITE_RAM);
        dat(8'h77);
        @(posedge clk); #1 bus.oled_cs = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("idle_on_cs", 32'(dut.state), 32'(ST_IDLE));
        bus.oled_cs = 1'b0;
        repeat (4) @(posedge clk);
        cmd_q.push_back({CMD_WRITE_RAM, 16'h0000});
        cmd(CMD_WRITE_RAM);
        pix_q.push_back({8'd16, 8'd5, 16'h4321});
        dat(8'h43); dat(8'h21);
        drain("drain_cs_drop");

        cmd(CMD_SET_COL); dat(8'h01);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_disp_on", 32'(disp_on), 32'd0);
        chk("mid_rst_cmd", 32'({cmd_code, cmd_args}), 32'd0);
        chk("mid_rst_pix", 32'({pix_x, pix_y, pix_data}), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        cmd_q.push_back({CMD_SET_COL, 16'h0102});
        cmd(CMD_SET_COL); dat(8'h01); dat(8'h02);
        cmd_q.push_back({CMD_WRITE_RAM, 16'h0000});
        cmd(CMD_WRITE_RAM);
        pix_q.push_back({8'd1, 8'd0, 16'h0FF0});
        dat(8'h0F); dat(8'hF0);
        drain("drain_after_rst");
        chk("err_after_rst", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
